// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator: shared edge- or center-aligned counter, per-channel duty compare.
// New period/duty/mode values are staged and take effect only at a period boundary.
module pwm_multichannel #(
   parameter int unsigned B              = 8,
   parameter int unsigned CH_BITS        = 2,
   parameter int unsigned DEFAULT_PERIOD = 100,
   parameter int unsigned DEFAULT_DUTY   = 50
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     center,
   input  logic                     period_we,
   input  logic [B-1:0]             period_in,
   input  logic                     duty_we,
   input  logic [CH_BITS-1:0]       duty_ch,
   input  logic [B-1:0]             duty_in,
   output logic [(2**CH_BITS)-1:0]  pwm_out,
   output logic                     period_tick,
   output logic                     busy
);

   localparam int unsigned N = 2 ** CH_BITS;
   localparam logic [B-1:0] DefPeriod = B'(DEFAULT_PERIOD);
   localparam logic [B-1:0] DefDuty   = B'(DEFAULT_DUTY);
   localparam logic [B-1:0] MinPeriod = B'(2);
   localparam logic [B-1:0] One       = B'(1);

   typedef enum logic {StIdle, StRun} state_t;

   state_t       state;
   logic [B-1:0] cnt;
   logic         down;
   logic         stop_pend;
   logic         mode;
   logic [B-1:0] period_pend;
   logic [B-1:0] period_act;
   logic [B-1:0] duty_pend [N];
   logic [B-1:0] duty_act  [N];

   logic [B-1:0] period_next;
   logic [B-1:0] duty_next [N];
   logic [B-1:0] last;
   logic         boundary;

   // Pending values as they will be after this cycle's writes, so a write on the
   // boundary cycle lands directly in the next period.
   always_comb begin
      period_next = period_pend;
      if (period_we) begin
         period_next = (period_in < MinPeriod) ? MinPeriod : period_in;
      end
      for (int i = 0; i < N; i++) begin
         duty_next[i] = duty_pend[i];
         if (duty_we && (duty_ch == CH_BITS'(i))) begin
            duty_next[i] = duty_in;
         end
      end
   end

   always_comb begin
      last     = period_act - One;
      boundary = (state == StRun) && (mode ? (down && (cnt == '0)) : (cnt == last));
   end

   always_comb begin
      busy        = (state == StRun);
      period_tick = boundary;
      for (int i = 0; i < N; i++) begin
         pwm_out[i] = (state == StRun) && (cnt < duty_act[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         cnt         <= '0;
         down        <= 1'b0;
         stop_pend   <= 1'b0;
         mode        <= 1'b0;
         period_pend <= DefPeriod;
         period_act  <= DefPeriod;
         for (int i = 0; i < N; i++) begin
            duty_pend[i] <= DefDuty;
            duty_act[i]  <= DefDuty;
         end
      end else begin
         period_pend <= period_next;
         duty_pend   <= duty_next;
         unique case (state)
            StIdle: begin
               cnt       <= '0;
               down      <= 1'b0;
               stop_pend <= 1'b0;
               if (start && !stop) begin
                  state      <= StRun;
                  period_act <= period_next;
                  duty_act   <= duty_next;
                  mode       <= center;
               end
            end
            StRun: begin
               if (boundary) begin
                  cnt        <= '0;
                  down       <= 1'b0;
                  period_act <= period_next;
                  duty_act   <= duty_next;
                  mode       <= center;
                  if (stop_pend || stop) begin
                     state     <= StIdle;
                     stop_pend <= 1'b0;
                  end
               end else begin
                  if (stop) begin
                     stop_pend <= 1'b1;
                  end
                  // Center mode holds the top count one extra cycle while turning around.
                  if (down) begin
                     cnt <= cnt - One;
                  end else if (mode && (cnt == last)) begin
                     down <= 1'b1;
                  end else begin
                     cnt <= cnt + One;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: directed scenario tables plus randomized traffic against
// a period-position reference model.
module tb_pwm_multichannel;

   logic       clk = 1'b0;
   logic       reset, start, stop, center, period_we, duty_we;
   logic [7:0] period_in, duty_in;
   logic [1:0] duty_ch;
   logic [3:0] pwm_out;
   logic       period_tick, busy;

   pwm_multichannel #(
      .B(8), .CH_BITS(2), .DEFAULT_PERIOD(100), .DEFAULT_DUTY(50)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .center(center),
      .period_we(period_we), .period_in(period_in), .duty_we(duty_we),
      .duty_ch(duty_ch), .duty_in(duty_in), .pwm_out(pwm_out),
      .period_tick(period_tick), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: position t within the current period, length P or 2P.
   int m_run, m_t, m_pa, m_mode, m_pp, m_sp;
   int m_da[4];
   int m_dp[4];

   logic       s_busy, s_tick;
   logic [3:0] s_pwm;
   bit         g_center = 0;

   typedef struct { int k; bit busy; bit [3:0] pwm; bit tick; } chk_t;
   typedef struct { int ch; int duty; int high; } duty_t;
   chk_t  tab1[$];
   duty_t tab2[$];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_t = 0; m_pa = 100; m_pp = 100; m_mode = 0; m_sp = 0;
      for (int i = 0; i < 4; i++) begin m_da[i] = 50; m_dp[i] = 50; end
   endtask

   task automatic step(input bit rst, input bit st, input bit sp, input bit cen,
                       input bit pwe, input int pin, input bit dwe, input int dch,
                       input int din);
      int len, c, pp_n;
      int dp_n[4];
      bit [3:0] e_pwm;
      reset = rst; start = st; stop = sp; center = cen; period_we = pwe;
      period_in = 8'(pin); duty_we = dwe; duty_ch = 2'(dch); duty_in = 8'(din);
      @(negedge clk);
      len = m_mode ? 2 * m_pa : m_pa;
      c = 0;
      if (m_run != 0) c = (m_mode != 0 && m_t >= m_pa) ? (2 * m_pa - 1 - m_t) : m_t;
      for (int i = 0; i < 4; i++) e_pwm[i] = (m_run != 0) && (c < m_da[i]);
      s_busy = busy; s_pwm = pwm_out; s_tick = period_tick;
      check("model_busy", int'(busy), m_run);
      check("model_pwm", int'(pwm_out), int'(e_pwm));
      check("model_tick", int'(period_tick), int'(m_run != 0 && m_t == len - 1));
      pp_n = pwe ? ((pin < 2) ? 2 : pin) : m_pp;
      for (int i = 0; i < 4; i++) dp_n[i] = (dwe && dch == i) ? din : m_dp[i];
      if (rst) begin
         model_reset();
      end else begin
         if (m_run == 0) begin
            if (st && !sp) begin
               m_run = 1; m_t = 0; m_pa = pp_n; m_da = dp_n; m_mode = cen; m_sp = 0;
            end
         end else if (m_t == len - 1) begin
            m_t = 0; m_pa = pp_n; m_da = dp_n; m_mode = cen;
            if (m_sp != 0 || sp) begin m_run = 0; m_sp = 0; end
         end else begin
            m_t++;
            if (sp) m_sp = 1;
         end
         m_pp = pp_n; m_dp = dp_n;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      step(0, 0, 0, g_center, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, g_center, 0, 0, 0, 0, 0);
   endtask

   task automatic do_start();
      step(0, 1, 0, g_center, 0, 0, 0, 0, 0);
   endtask

   int hi[4];
   int hi2[4];

   initial begin
      tab1.push_back('{0,   1'b1, 4'hF, 1'b0});
      tab1.push_back('{49,  1'b1, 4'hF, 1'b0});
      tab1.push_back('{50,  1'b1, 4'h0, 1'b0});
      tab1.push_back('{98,  1'b1, 4'h0, 1'b0});
      tab1.push_back('{99,  1'b1, 4'h0, 1'b1});
      tab1.push_back('{100, 1'b1, 4'hF, 1'b0});
      tab1.push_back('{149, 1'b1, 4'hF, 1'b0});
      tab1.push_back('{150, 1'b1, 4'h0, 1'b0});
      tab1.push_back('{199, 1'b1, 4'h0, 1'b1});
      tab2.push_back('{0, 0, 0});
      tab2.push_back('{1, 255, 100});
      tab2.push_back('{2, 1, 1});
      tab2.push_back('{3, 99, 99});

      model_reset();
      do_reset();
      do_reset();
      idle();
      check("reset_busy", int'(s_busy), 0);
      check("reset_pwm", int'(s_pwm), 0);
      check("reset_tick", int'(s_tick), 0);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      idle();
      check("start_with_stop_ignored", int'(s_busy), 0);

      // Default waveform across two periods.
      do_start();
      for (int k = 0; k < 200; k++) begin
         idle();
         foreach (tab1[j]) begin
            if (tab1[j].k == k) begin
               check("dflt_busy", int'(s_busy), int'(tab1[j].busy));
               check("dflt_pwm", int'(s_pwm), int'(tab1[j].pwm));
               check("dflt_tick", int'(s_tick), int'(tab1[j].tick));
            end
         end
      end

      // Mid-period duty write affects the next period only.
      do_reset();
      do_start();
      hi = '{0, 0, 0, 0}; hi2 = '{0, 0, 0, 0};
      for (int k = 0; k < 200; k++) begin
         if (k == 10) step(0, 0, 0, 0, 0, 0, 1, 1, 20);
         else idle();
         for (int i = 0; i < 4; i++) begin
            if (k < 100) hi[i] += int'(s_pwm[i]);
            else hi2[i] += int'(s_pwm[i]);
         end
      end
      check("wr_ch1_this_period", hi[1], 50);
      check("wr_ch1_next_period", hi2[1], 20);
      check("wr_ch0_next_period", hi2[0], 50);
      check("wr_ch3_next_period", hi2[3], 50);

      // Duty extremes.
      do_reset();
      foreach (tab2[j]) step(0, 0, 0, 0, 0, 0, 1, tab2[j].ch, tab2[j].duty);
      do_start();
      hi = '{0, 0, 0, 0};
      for (int k = 0; k < 100; k++) begin
         idle();
         for (int i = 0; i < 4; i++) hi[i] += int'(s_pwm[i]);
      end
      foreach (tab2[j]) check("extreme_duty_high", hi[tab2[j].ch], tab2[j].high);

      // Center-aligned, P=10, ch0 D=3.
      do_reset();
      step(0, 0, 0, 0, 1, 10, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 3);
      g_center = 1;
      do_start();
      for (int k = 0; k < 40; k++) begin
         idle();
         check("center_ch0", int'(s_pwm[0]), int'((k % 20) < 3 || (k % 20) >= 17));
         check("center_tick", int'(s_tick), int'((k % 20) == 19));
      end
      g_center = 0;

      // Stop mid-period completes the period.
      do_reset();
      do_start();
      for (int k = 0; k < 101; k++) begin
         if (k == 30) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
         else idle();
         if (k >= 95 && k <= 99) check("stop_tick", int'(s_tick), int'(k == 99));
         if (k == 99) check("stop_busy_last", int'(s_busy), 1);
         if (k == 100) begin
            check("stop_busy_after", int'(s_busy), 0);
            check("stop_pwm_after", int'(s_pwm), 0);
         end
      end

      // Reset mid-period discards a pending period write.
      do_reset();
      do_start();
      for (int k = 0; k < 41; k++) begin
         if (k == 5) step(0, 0, 0, 0, 1, 60, 0, 0, 0);
         else if (k == 40) do_reset();
         else idle();
      end
      idle();
      check("rst_mid_busy", int'(s_busy), 0);
      check("rst_mid_pwm", int'(s_pwm), 0);
      do_start();
      for (int k = 0; k < 101; k++) begin
         idle();
         if (k >= 55) check("rst_mid_tick", int'(s_tick), int'(k == 99));
      end

      // Randomized traffic against the model.
      do_reset();
      step(0, 0, 0, 0, 1, 7, 0, 0, 0);
      for (int n = 0; n < 4000; n++) begin
         step($urandom_range(0, 999) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 29) == 0, int'($urandom_range(0, 20)),
              $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 25)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_multichannel.md
PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

Interface
REQ-001 SHALL have parameter B, default 8, counter/period/duty width in bits.
REQ-002 SHALL have parameter CH_BITS, default 2, channel-select width; channel count N = 2**CH_BITS.
REQ-003 SHALL have parameter DEFAULT_PERIOD, default 100, period loaded at reset; SHALL be 2..2**B-1.
REQ-004 SHALL have parameter DEFAULT_DUTY, default 50, duty of every channel at reset.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin generation; sampled only in IDLE.
REQ-008 stop  input  1  request stop at end of the current period; sampled only in RUN.
REQ-009 center  input  1  mode for subsequent periods: 0 = edge-aligned, 1 = center-aligned.
REQ-010 period_we  input  1  write period_in to the pending period register.
REQ-011 period_in  input  B  requested period value P.
REQ-012 duty_we  input  1  write duty_in to the pending duty of channel duty_ch.
REQ-013 duty_ch  input  CH_BITS  channel index for duty_we.
REQ-014 duty_in  input  B  requested duty value D.
REQ-015 pwm_out  output  N  per-channel PWM waveform.
REQ-016 period_tick  output  1  one-cycle pulse on the last cycle of each period in RUN.
REQ-017 busy  output  1  high while in RUN.

Function
REQ-018 SHALL implement a two-state FSM: IDLE, RUN.
REQ-019 IDLE -> RUN SHALL occur when start=1 and stop=0; start with stop=1 in IDLE SHALL be ignored; stop in IDLE SHALL be ignored.
REQ-020 On IDLE -> RUN, cnt SHALL be 0 and active period, duties and mode SHALL load from pending values.
REQ-021 start in RUN SHALL be ignored.
REQ-022 Edge mode: cnt SHALL count 0..P-1, then wrap to 0; period = P cycles; boundary cycle = cnt==P-1.
REQ-023 Center mode: cnt SHALL count up 0..P-1, then down P-1..0, each endpoint held one cycle; period = 2P cycles; boundary cycle = down phase at cnt==0.
REQ-024 pwm_out[i] SHALL be 1 iff state==RUN and cnt < active duty[i]; it SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-025 D=0 SHALL give constant 0; D>=P SHALL give constant 1 for the whole period.
REQ-026 Period writes with period_in < 2 SHALL store 2.
REQ-027 Writes SHALL update pending registers only; active values SHALL change only at the edge ending a boundary cycle or on entering RUN.
REQ-028 A write coinciding with the boundary cycle SHALL take effect in the very next period (write-through).
REQ-029 center SHALL be sampled into active mode at each boundary edge and on entering RUN; the next period SHALL start with cnt=0, up phase.
REQ-030 period_tick SHALL assert on every boundary cycle in RUN, including the final one before a stop.
REQ-031 stop in RUN SHALL set a stop-pending flag; at the next boundary edge the block SHALL go to IDLE and clear the flag; a stop asserted on the boundary cycle SHALL stop at that boundary.
REQ-032 In IDLE, cnt SHALL be held at 0 and pwm_out SHALL be all 0.

Reset
REQ-033 reset SHALL force: state IDLE, cnt 0, stop flag 0, mode edge, pending and active period = DEFAULT_PERIOD, all pending and active duties = DEFAULT_DUTY, pwm_out 0, period_tick 0, busy 0.
REQ-034 reset SHALL override all other inputs in the same cycle, including mid-period.

Verification (B=8, CH_BITS=2, defaults)
REQ-035 Reset, then start pulse -> busy=1; pwm_out=4'hF for 50 cycles, then 0 for 50; period_tick every 100 cycles.
REQ-036 duty ch1 = 20 written at cnt=10 -> ch1 stays high 50 cycles this period, 20 the next; other channels unchanged.
REQ-037 Duties 0/255/1/99 with P=100 -> ch0 constant 0; ch1 constant 1; ch2 high 1 of 100; ch3 high 99 of 100.
REQ-038 center=1, P=10, ch0 D=3 -> 20-cycle period; ch0 high for cnt 0,1,2 up and 2,1,0 down (3 high, 14 low, 6 high across the boundary).
REQ-039 stop pulse at cnt=30 -> run continues; period_tick at cnt=99; next cycle busy=0 and pwm_out=0.
REQ-040 reset at cnt=40 after a period write of 60 -> next cycle busy=0, pwm_out=0; after restart, period is 100 cycles.
